multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control FSM for the multi-cycle RV32I core; the control end of the multi-cycle datapath.
- Consumes the latched instruction word and the ALU zero flag.
- Drives every datapath enable and mux select, one state per cycle.
- Supported instructions: R-type add/sub/and/or/xor/slt; I-type addi/andi/ori/xori/slti; lw; sw; beq/bne/blt/bge; jal; jalr; lui.

Parameters:
ALU_ADD, 4'd0, alu_control code for add
ALU_SUB, 4'd1, subtract
ALU_AND, 4'd2, bitwise and
ALU_OR, 4'd3, bitwise or
ALU_XOR, 4'd4, bitwise xor
ALU_SLT, 4'd5, signed set-less-than (result 1/0)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
instr  in  32  instruction register output
zero  in  1  ALU zero flag (combinational, current cycle)
reg_write  out  1  register file write enable
mem_write  out  1  memory write enable
for_data_mem  out  1  1 = data-space access
adr_src  out  1  memory address: 0 pc, 1 result
IR_write  out  1  instruction register load
pc_write  out  1  PC load from result
alu_srca  out  2  0 pc, 1 old_pc, 2 regA, 3 zero
alu_srcb  out  2  0 regB, 1 imm, 2 const 4, 3 zero
wd_sel  out  2  reg write data: 0 result, 1 pc; bit1 always 0
res_src  out  2  0 alu_reg, 1 data_reg, 2 alu_result, 3 imm_ext
alu_control  out  4  ALU operation (parameter codes)
imm_src  out  4  0 I, 1 S, 2 B, 3 J, 4 U; others unused
illegal_instr  out  1  one-cycle pulse on unsupported opcode/funct

Behaviour:
- State register is the only storage. Outputs are combinational from state, opcode, funct3 and funct7[5]. Unlisted outputs are 0 in every state.
- rst low: state forced to FETCH asynchronously; all outputs forced 0 while rst is low. Reset mid-instruction abandons it with no further writes.
- FETCH: adr_src=0, IR_write=1, srca=0, srcb=2, ADD, res_src=2, pc_write=1 -> DECODE.
- DECODE: srca=1, srcb=1, ADD. imm_src = J for jal, else B. alu_reg captures branch/jal target. Next state by opcode:
  - 0000011/0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - else illegal_instr=1, -> FETCH with no writes.
- MEM_ADR: srca=2, srcb=1, imm_src=I (lw) or S (sw), ADD -> MEM_READ (lw) / MEM_WRITE (sw).
- MEM_READ: adr_src=1, res_src=0, for_data_mem=1 -> MEM_WB.
- MEM_WB: res_src=1, wd_sel=0, reg_write=1 -> FETCH.
- MEM_WRITE: adr_src=1, res_src=0, for_data_mem=1, mem_write=1 -> FETCH.
- EXEC_R: srca=2, srcb=0. alu_control by funct3/funct7[5]: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 100 XOR, 010 SLT. Any other funct3/funct7 combination: illegal_instr pulse, -> FETCH. Valid -> ALU_WB.
- EXEC_I: srca=2, srcb=1, imm_src=I. Same funct3 map, funct7 ignored, no SUB. Unsupported funct3: illegal_instr pulse, -> FETCH. Valid -> ALU_WB.
- ALU_WB: res_src=0, wd_sel=0, reg_write=1 -> FETCH.
- BRANCH: srca=2, srcb=0, res_src=0.
  - beq: SUB, pc_write=zero.
  - bne: SUB, pc_write=~zero.
  - blt: SLT, pc_write=~zero.
  - bge: SLT, pc_write=zero.
  - Other funct3: illegal_instr pulse, no pc_write.
  - -> FETCH.
- JAL: res_src=0, pc_write=1, wd_sel=1, reg_write=1 -> FETCH. Link value = pc = old_pc+4.
- JALR: srca=2, srcb=1, imm_src=I, ADD, res_src=2, pc_write=1, wd_sel=1, reg_write=1 -> FETCH. Target bit0 not cleared.
- LUI: imm_src=U, res_src=3, wd_sel=0, reg_write=1 -> FETCH.
- Cycles per instruction: lw 5; sw, R, I 4; branch, jal, jalr, lui 3; illegal 2.
- reg_write and mem_write are never both 1. pc_write is asserted at most once per instruction after FETCH.

Test Plan:
- rst=0 held mid-MEM_ADR of lw -> all outputs 0 immediately; after rst=1 -> FETCH outputs (IR_write=1, pc_write=1, srcb=2).
- instr=0x002081B3 (add x3,x1,x2) -> FETCH, DECODE, EXEC_R (alu_control=0), ALU_WB (reg_write=1, res_src=0); 4 cycles.
- instr=0x0080A283 (lw x5,8(x1)) -> MEM_ADR imm_src=0, MEM_READ adr_src=1, for_data_mem=1, MEM_WB res_src=1, reg_write=1; 5 cycles. instr=0x00512623 (sw) -> mem_write=1 in cycle 4 only, imm_src=1.
- instr=0x00208863 (beq): zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0. Both cases 3 cycles, alu_control=1.
- instr=0x008000EF (jal x1,+8) -> DECODE imm_src=3; JAL: wd_sel=1, reg_write=1, pc_write=1, res_src=0.
- instr=0x0000007F -> illegal_instr=1 in DECODE only, no write enables, FETCH next; instr=0x0020F1B3 (and) then writes normally.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// There is no handshake: every control output is a level, valid in every cycle.
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        zero;
  logic        reg_write;
  logic        mem_write;
  logic        for_data_mem;
  logic        adr_src;
  logic        IR_write;
  logic        pc_write;
  logic [1:0]  alu_srca;
  logic [1:0]  alu_srcb;
  logic [1:0]  wd_sel;
  logic [1:0]  res_src;
  logic [3:0]  alu_control;
  logic [3:0]  imm_src;
  logic        illegal_instr;

  modport master (
    input  instr, zero,
    output reg_write, mem_write, for_data_mem, adr_src, IR_write, pc_write,
           alu_srca, alu_srcb, wd_sel, res_src, alu_control, imm_src, illegal_instr
  );

  modport slave (
    output instr, zero,
    input  reg_write, mem_write, for_data_mem, adr_src, IR_write, pc_write,
           alu_srca, alu_srcb, wd_sel, res_src, alu_control, imm_src, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: one state per cycle, all datapath
// controls decoded combinationally from the state and the latched instruction.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus,
  output logic [3:0]                     o_dbg_state
);
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  localparam logic [3:0] IMM_I = 4'd0;
  localparam logic [3:0] IMM_S = 4'd1;
  localparam logic [3:0] IMM_B = 4'd2;
  localparam logic [3:0] IMM_J = 4'd3;
  localparam logic [3:0] IMM_U = 4'd4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADR   = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] EXEC_R    = 4'd6;
  localparam logic [3:0] EXEC_I    = 4'd7;
  localparam logic [3:0] ALU_WB    = 4'd8;
  localparam logic [3:0] BRANCH    = 4'd9;
  localparam logic [3:0] JAL       = 4'd10;
  localparam logic [3:0] JALR      = 4'd11;
  localparam logic [3:0] LUI       = 4'd12;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_alu_ok;
  logic [3:0] w_alu_op;
  logic       w_unused_instr;

  logic       w_reg_write, w_mem_write, w_for_data_mem, w_adr_src, w_ir_write, w_pc_write;
  logic [1:0] w_alu_srca, w_alu_srcb, w_wd_sel, w_res_src;
  logic [3:0] w_alu_control, w_imm_src;
  logic       w_illegal;

  assign w_op           = bus.instr[6:0];
  assign w_f3           = bus.instr[14:12];
  assign w_f7b5         = bus.instr[30];
  assign w_unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FETCH;
    else      r_state <= w_next;
  end

  // Shared funct3 map for EXEC_R/EXEC_I; funct7[5] only matters for R-type.
  always_comb begin
    w_alu_ok = 1'b1;
    w_alu_op = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu_op = (w_op == OP_R && w_f7b5) ? ALU_SUB : ALU_ADD;
      3'b111:  w_alu_op = ALU_AND;
      3'b110:  w_alu_op = ALU_OR;
      3'b100:  w_alu_op = ALU_XOR;
      3'b010:  w_alu_op = ALU_SLT;
      default: w_alu_ok = 1'b0;
    endcase
    if (w_op == OP_R && w_f7b5 && w_f3 != 3'b000) w_alu_ok = 1'b0;
  end

  always_comb begin
    w_next         = FETCH;
    w_reg_write    = 1'b0;
    w_mem_write    = 1'b0;
    w_for_data_mem = 1'b0;
    w_adr_src      = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_alu_srca     = 2'd0;
    w_alu_srcb     = 2'd0;
    w_wd_sel       = 2'd0;
    w_res_src      = 2'd0;
    w_alu_control  = ALU_ADD;
    w_imm_src      = IMM_I;
    w_illegal      = 1'b0;
    // Holding rst low silences every control, even though the state sits in FETCH.
    if (rst) begin
      case (r_state)
        FETCH: begin
          w_ir_write = 1'b1;
          w_alu_srcb = 2'd2;
          w_res_src  = 2'd2;
          w_pc_write = 1'b1;
          w_next     = DECODE;
        end
        DECODE: begin
          w_alu_srca = 2'd1;
          w_alu_srcb = 2'd1;
          w_imm_src  = (w_op == OP_JAL) ? IMM_J : IMM_B;
          case (w_op)
            OP_LOAD, OP_STORE: w_next = MEM_ADR;
            OP_R:              w_next = EXEC_R;
            OP_I:              w_next = EXEC_I;
            OP_BR:             w_next = BRANCH;
            OP_JAL:            w_next = JAL;
            OP_JALR:           w_next = JALR;
            OP_LUI:            w_next = LUI;
            default:           w_illegal = 1'b1;
          endcase
        end
        MEM_ADR: begin
          w_alu_srca = 2'd2;
          w_alu_srcb = 2'd1;
          w_imm_src  = (w_op == OP_STORE) ? IMM_S : IMM_I;
          w_next     = (w_op == OP_STORE) ? MEM_WRITE : MEM_READ;
        end
        MEM_READ: begin
          w_adr_src      = 1'b1;
          w_for_data_mem = 1'b1;
          w_next         = MEM_WB;
        end
        MEM_WB: begin
          w_res_src   = 2'd1;
          w_reg_write = 1'b1;
        end
        MEM_WRITE: begin
          w_adr_src      = 1'b1;
          w_for_data_mem = 1'b1;
          w_mem_write    = 1'b1;
        end
        EXEC_R, EXEC_I: begin
          w_alu_srca = 2'd2;
          w_alu_srcb = (r_state == EXEC_I) ? 2'd1 : 2'd0;
          if (w_alu_ok) begin
            w_alu_control = w_alu_op;
            w_next        = ALU_WB;
          end else begin
            w_illegal = 1'b1;
          end
        end
        ALU_WB: w_reg_write = 1'b1;
        BRANCH: begin
          w_alu_srca = 2'd2;
          case (w_f3)
            3'b000: begin w_alu_control = ALU_SUB; w_pc_write = bus.zero;  end
            3'b001: begin w_alu_control = ALU_SUB; w_pc_write = ~bus.zero; end
            3'b100: begin w_alu_control = ALU_SLT; w_pc_write = ~bus.zero; end
            3'b101: begin w_alu_control = ALU_SLT; w_pc_write = bus.zero;  end
            default: w_illegal = 1'b1;
          endcase
        end
        // alu_reg already holds the jal target computed during DECODE.
        JAL: begin
          w_pc_write  = 1'b1;
          w_wd_sel    = 2'd1;
          w_reg_write = 1'b1;
        end
        JALR: begin
          w_alu_srca  = 2'd2;
          w_alu_srcb  = 2'd1;
          w_res_src   = 2'd2;
          w_pc_write  = 1'b1;
          w_wd_sel    = 2'd1;
          w_reg_write = 1'b1;
        end
        LUI: begin
          w_imm_src   = IMM_U;
          w_res_src   = 2'd3;
          w_reg_write = 1'b1;
        end
        default: w_next = FETCH;
      endcase
    end
  end

  assign bus.reg_write     = w_reg_write;
  assign bus.mem_write     = w_mem_write;
  assign bus.for_data_mem  = w_for_data_mem;
  assign bus.adr_src       = w_adr_src;
  assign bus.IR_write      = w_ir_write;
  assign bus.pc_write      = w_pc_write;
  assign bus.alu_srca      = w_alu_srca;
  assign bus.alu_srcb      = w_alu_srcb;
  assign bus.wd_sel        = w_wd_sel;
  assign bus.res_src       = w_res_src;
  assign bus.alu_control   = w_alu_control;
  assign bus.imm_src       = w_imm_src;
  assign bus.illegal_instr = w_illegal;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model pushes the
// expected per-cycle control vector; a negedge monitor pops and compares.
module tb_multicycle_controller;
  localparam int W = 23;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] dbg_state;
  logic [W-1:0] act;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // {reg_write, mem_write, for_data_mem, adr_src, IR_write, pc_write,
  //  alu_srca, alu_srcb, wd_sel, res_src, alu_control, imm_src, illegal_instr}
  assign act = {bus.reg_write, bus.mem_write, bus.for_data_mem, bus.adr_src, bus.IR_write,
                bus.pc_write, bus.alu_srca, bus.alu_srcb, bus.wd_sel, bus.res_src,
                bus.alu_control, bus.imm_src, bus.illegal_instr};

  function automatic logic [W-1:0] pk(input logic rw, mw, fdm, adr, ir, pcw,
                                      input logic [1:0] sa, sb, wd, res,
                                      input logic [3:0] alu, imm, input logic ill);
    return {rw, mw, fdm, adr, ir, pcw, sa, sb, wd, res, alu, imm, ill};
  endfunction

  // Reference: expand one instruction into its cycle-by-cycle control vectors.
  task automatic model_push(input logic [31:0] ins, input logic z, output int n);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7b5, ok, take, legal_op, is_r;
    logic [3:0] alu;
    op = ins[6:0]; f3 = ins[14:12]; f7b5 = ins[30];
    legal_op = op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    exp_q.push_back(pk(0,0,0,0,1,1, 2'd0,2'd2,2'd0,2'd2, 4'd0, 4'd0, 0));
    exp_q.push_back(pk(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 4'd0, (op == OP_JAL) ? 4'd3 : 4'd2, !legal_op));
    n = 2;
    case (op)
      OP_LOAD: begin
        exp_q.push_back(pk(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 4'd0, 4'd0, 0));
        exp_q.push_back(pk(0,0,1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 4'd0, 4'd0, 0));
        exp_q.push_back(pk(1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd1, 4'd0, 4'd0, 0));
        n = 5;
      end
      OP_STORE: begin
        exp_q.push_back(pk(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 4'd0, 4'd1, 0));
        exp_q.push_back(pk(0,1,1,1,0,0, 2'd0,2'd0,2'd0,2'd0, 4'd0, 4'd0, 0));
        n = 4;
      end
      OP_R, OP_I: begin
        is_r = (op == OP_R);
        ok = 1'b1; alu = 4'd0;
        case (f3)
          3'b000: alu = (is_r && f7b5) ? 4'd1 : 4'd0;
          3'b111: alu = 4'd2;
          3'b110: alu = 4'd3;
          3'b100: alu = 4'd4;
          3'b010: alu = 4'd5;
          default: ok = 1'b0;
        endcase
        if (is_r && f7b5 && f3 != 3'b000) ok = 1'b0;
        exp_q.push_back(pk(0,0,0,0,0,0, 2'd2, is_r ? 2'd0 : 2'd1, 2'd0,2'd0, ok ? alu : 4'd0, 4'd0, !ok));
        n = 3;
        if (ok) begin
          exp_q.push_back(pk(1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 4'd0, 4'd0, 0));
          n = 4;
        end
      end
      OP_BR: begin
        ok = 1'b1; alu = 4'd0; take = 1'b0;
        case (f3)
          3'b000: begin alu = 4'd1; take = z;  end
          3'b001: begin alu = 4'd1; take = !z; end
          3'b100: begin alu = 4'd5; take = !z; end
          3'b101: begin alu = 4'd5; take = z;  end
          default: ok = 1'b0;
        endcase
        exp_q.push_back(pk(0,0,0,0,0, ok && take, 2'd2,2'd0,2'd0,2'd0, alu, 4'd0, !ok));
        n = 3;
      end
      OP_JAL: begin
        exp_q.push_back(pk(1,0,0,0,0,1, 2'd0,2'd0,2'd1,2'd0, 4'd0, 4'd0, 0));
        n = 3;
      end
      OP_JALR: begin
        exp_q.push_back(pk(1,0,0,0,0,1, 2'd2,2'd1,2'd1,2'd2, 4'd0, 4'd0, 0));
        n = 3;
      end
      OP_LUI: begin
        exp_q.push_back(pk(1,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3, 4'd0, 4'd4, 0));
        n = 3;
      end
      default: n = 2;
    endcase
  endtask

  // Called just after a rising edge while the DUT is in FETCH.
  task automatic run_instr(input logic [31:0] ins, input logic z);
    int n;
    bus.instr = ins;
    bus.zero  = z;
    model_push(ins, z, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Abandon a lw in MEM_ADR: outputs drop at once, then restart in FETCH.
  task automatic reset_mid_lw();
    bus.instr = 32'h0080A283;
    bus.zero  = 1'b0;
    exp_q.push_back(pk(0,0,0,0,1,1, 2'd0,2'd2,2'd0,2'd2, 4'd0, 4'd0, 0));
    exp_q.push_back(pk(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 4'd0, 4'd2, 0));
    repeat (2) @(posedge clk);
    #1;
    check_vec("mem_adr_before_reset", pk(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 4'd0, 4'd0, 0));
    rst = 1'b0;
    #1;
    check_vec("reset_outputs_zero", '0);
    @(posedge clk);
    #1;
    check_vec("reset_held_zero", '0);
    rst = 1'b1;
    #1;
    check_vec("reset_release_fetch", pk(0,0,0,0,1,1, 2'd0,2'd2,2'd0,2'd2, 4'd0, 4'd0, 0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  op;
    ins = $urandom();
    case ($urandom_range(0, 9))
      0: op = OP_LOAD;
      1: op = OP_STORE;
      2: op = OP_R;
      3: op = OP_I;
      4: op = OP_BR;
      5: op = OP_JAL;
      6: op = OP_JALR;
      7: op = OP_LUI;
      8: op = OP_BR;
      default: op = ins[6:0];
    endcase
    ins[6:0] = op;
    if (op == OP_R) begin
      ins[31]    = 1'b0;
      ins[29:25] = 5'd0;
    end
    return ins;
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      cycle_no++;
      checks++;
      if (bus.reg_write && bus.mem_write) begin
        failures++;
        $display("FAIL write_exclusive actual=11 required=not_both cycle=%0d", cycle_no);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_cycle actual=%h required=none cycle=%0d", act, cycle_no);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL ctrl_vec cycle=%0d instr=%h zero=%0b actual=%h required=%h",
                   cycle_no, bus.instr, bus.zero, act, e);
        end
      end
    end
  end

  initial begin
    bus.instr = 32'h0;
    bus.zero  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_state_zero", '0);
    rst = 1'b1;
    #1;
    reset_mid_lw();
    run_instr(32'h002081B3, 1'b0);
    run_instr(32'h0080A283, 1'b0);
    run_instr(32'h00512623, 1'b1);
    run_instr(32'h00208863, 1'b1);
    run_instr(32'h00208863, 1'b0);
    run_instr(32'h008000EF, 1'b0);
    run_instr(32'h0000007F, 1'b0);
    run_instr(32'h0020F1B3, 1'b0);
    run_instr(32'h40208033, 1'b0);
    run_instr(32'h4020F033, 1'b0);
    run_instr(32'h0020C463, 1'b0);
    run_instr(32'h0020D463, 1'b1);
    run_instr(32'h00009463, 1'b1);
    run_instr(32'h00102013, 1'b0);
    run_instr(32'h00101013, 1'b0);
    run_instr(32'h000080E7, 1'b0);
    run_instr(32'h123450B7, 1'b0);
    for (int i = 0; i < 200; i++) begin
      run_instr(rand_instr(), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained actual=%0d required=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
